mb_mode_select: RTL and testbench
=================================

MB_MODE_SELECT -- requirements
Module: mb_mode_select

Interface
REQ-001 SHALL have parameter NUM_CAND, default 2, meaning number of luma candidate predictors (legal 2..4).
REQ-002 SHALL have parameter PAYLOAD_W, default 6144, meaning per-candidate payload width (ac levels plus reconstruction).
REQ-003 SHALL have parameter SCORE_W, default 64, meaning unsigned score width.
REQ-004 SHALL have parameter DC_MASK, default 1 (NUM_CAND bits), meaning bit i set = candidate i carries a DC-nz bit in cand_nz[i][24].
REQ-005 SHALL have parameter TIMEOUT, default 4095, meaning COLLECT cycle limit (used only under the macro).
REQ-006 SHALL use these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin macroblock.
- cand_done, in, NUM_CAND, per-candidate done pulse.
- cand_score, in, NUM_CAND*SCORE_W, scores; valid on done.
- cand_nz, in, NUM_CAND*32, Y nz [15:0] plus DC [24].
- cand_payload, in, NUM_CAND*PAYLOAD_W, levels/recon.
- uv_done, in, 1, chroma done pulse.
- uv_nz, in, 32, chroma nz in [23:16].
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accept.
- best_idx, out, 2, winning candidate.
- mbtype, out, 8, equals best_idx zero-extended.
- payload, out, PAYLOAD_W, winner payload.
- nz, out, 32, merged nz.
- skipped, out, 1, nz == 0.
- busy, out, 1, state != IDLE.
- err, out, 1, one-cycle timeout pulse.

Function
REQ-007 SHALL implement the FSM IDLE -> COLLECT -> COMPARE -> OUT -> IDLE.
REQ-008 IDLE: start=1 SHALL clear all sticky done flags and enter COLLECT; done pulses in IDLE SHALL be ignored.
REQ-009 COLLECT: on each cand_done[i], SHALL latch score/nz/payload of candidate i and set sticky flag i; uv_done SHALL latch uv_nz[23:16] and set the uv flag; simultaneous dones SHALL all be captured.
REQ-010 COLLECT SHALL exit to COMPARE on the edge at which all NUM_CAND+1 flags are set, counting pulses sampled on that same edge.
REQ-011 COMPARE SHALL take one candidate per cycle for NUM_CAND cycles: load candidate 0 as best, then replace best only if cand_score[i] < best score (strict, unsigned), so ties go to the lowest index.
REQ-012 out_valid SHALL rise exactly NUM_CAND+1 edges after the edge that completed COLLECT.
REQ-013 nz SHALL be {7'b0, DC_MASK[best] ? nz_best[24] : 1'b0, uv[7:0], nz_best[15:0]}; skipped SHALL equal (nz == 0).
REQ-014 OUT: outputs SHALL hold stable while out_valid=1 and out_ready=0; the valid&ready edge SHALL return to IDLE and drop out_valid.
REQ-015 start while busy=1 SHALL be ignored; repeated done for an already-set flag SHALL overwrite the latched data.
REQ-016 Back-to-back operation: start in the cycle after the handshake SHALL be accepted.

Reset
REQ-017 Asserting rst_n low SHALL immediately force IDLE, clear flags, and drive out_valid=0, best_idx=0, mbtype=0, payload=0, nz=0, skipped=0, busy=0, err=0, including mid-operation.
REQ-018 Release SHALL take effect synchronously on the next clk edge.

Configuration
REQ-019 Macro MB_MODE_SELECT_TIMEOUT_EN defined: a counter cleared on COLLECT entry; when it reaches TIMEOUT in COLLECT, the block SHALL pulse err for one cycle and return to IDLE without out_valid. Macro undefined: there SHALL be no counter, err SHALL be tied 0, and COLLECT SHALL wait indefinitely.

Verification
REQ-020 Scores 100 (c0) and 50 (c1), dones in different cycles, uv_nz[23:16]=0x03 -> best_idx=1; nz=0x0003_xxxx with DC bit 0; out_valid 3 edges after the last done.
REQ-021 Equal scores of 77, c0 nz[24]=1 and all else 0 -> best_idx=0, nz=0x0100_0000, skipped=0.
REQ-022 All nz=0, uv_nz=0 -> skipped=1, nz=0.
REQ-023 out_ready held 0 for 5 cycles -> outputs stable; a start pulse during that time is ignored; ready=1 -> IDLE next edge.
REQ-024 Reset asserted during COMPARE -> all outputs 0 asynchronously; a fresh start afterwards completes normally.
REQ-025 With the macro and TIMEOUT=10, uv_done never arrives -> err=1 for one cycle at cycle 10 of COLLECT, busy=0 after, out_valid never set.

Source files
------------

// File: rtl/mb_mode_select.sv
`default_nettype none
// ============================================================================
// Module      : mb_mode_select
// Description : Macroblock luma mode decision. Collects NUM_CAND candidate
//               predictor results plus the chroma result, selects the
//               lowest-score candidate (ties -> lowest index) over NUM_CAND
//               compare cycles, and presents the winner's payload together
//               with the merged non-zero map behind a valid/ready handshake.
// Ports       : clk, rst_n (async active-low)      - clock / reset
//               start                              - begin a macroblock
//               cand_done/score/nz/payload         - per-candidate results
//               uv_done, uv_nz                     - chroma result
//               out_valid, out_ready               - result handshake
//               best_idx, mbtype, payload, nz,
//               skipped                            - selected result
//               busy, err                          - status / timeout pulse
// Option      : define MB_MODE_SELECT_TIMEOUT_EN to abort COLLECT after
//               TIMEOUT cycles with a one-cycle err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mb_mode_select #(
    parameter int                  NUM_CAND  = 2,
    parameter int                  PAYLOAD_W = 6144,
    parameter int                  SCORE_W   = 64,
    parameter logic [NUM_CAND-1:0] DC_MASK   = NUM_CAND'(1),
    parameter int                  TIMEOUT   = 4095
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_CAND-1:0]           cand_done,
    input  logic [NUM_CAND*SCORE_W-1:0]   cand_score,
    input  logic [NUM_CAND*32-1:0]        cand_nz,
    input  logic [NUM_CAND*PAYLOAD_W-1:0] cand_payload,
    input  logic                          uv_done,
    input  logic [31:0]                   uv_nz,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    best_idx,
    output logic [7:0]                    mbtype,
    output logic [PAYLOAD_W-1:0]          payload,
    output logic [31:0]                   nz,
    output logic                          skipped,
    output logic                          busy,
    output logic                          err
);

    localparam int IDX_W = (NUM_CAND > 2) ? 2 : 1;
    localparam int CNT_W = (NUM_CAND > 3) ? 3 : 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMPARE = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // Captured candidate data; nz is kept as {DC bit, Y nz[15:0]}.
    logic [SCORE_W-1:0]   r_score   [NUM_CAND];
    logic [16:0]          r_nz_cap  [NUM_CAND];
    logic [PAYLOAD_W-1:0] r_pay_cap [NUM_CAND];
    logic [NUM_CAND-1:0]  r_flags;
    logic                 r_uv_flag;
    logic [7:0]           r_uv_nz;

    logic [CNT_W-1:0]     r_cmp_cnt;
    logic [IDX_W-1:0]     r_best_i;
    logic [SCORE_W-1:0]   r_best_score;

    logic [1:0]           r_best_idx;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [31:0]          r_nz;
    logic                 r_skipped;

    logic                 w_all_done;
    logic                 w_timeout;
    logic [IDX_W-1:0]     w_cmp_i;
    logic [16:0]          w_sel_nz;
    logic [31:0]          w_nz_merged;
    logic                 w_unused_bits;

    // Pulses sampled on the completing edge count toward completion.
    assign w_all_done  = (&(r_flags | cand_done)) & (r_uv_flag | uv_done);
    assign w_cmp_i     = r_cmp_cnt[IDX_W-1:0];
    assign w_sel_nz    = r_nz_cap[r_best_i];
    assign w_nz_merged = {7'b0, DC_MASK[r_best_i] & w_sel_nz[16], r_uv_nz, w_sel_nz[15:0]};
    assign w_unused_bits = &{1'b0, cand_nz, uv_nz};

`ifdef MB_MODE_SELECT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_timeout = (r_state == S_COLLECT) && !w_all_done &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Counter sits at zero outside COLLECT, so COLLECT entry always starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state == S_COLLECT)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else
                r_tmo_cnt <= '0;
        end
    end

    assign err = r_err;
`else
    localparam int c_unused_timeout = TIMEOUT;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (w_all_done)     w_state_nxt = S_COMPARE;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            // NUM_CAND compare steps, then one cycle to register the winner.
            S_COMPARE: if (r_cmp_cnt == CNT_W'(NUM_CAND)) w_state_nxt = S_OUT;
            S_OUT:     if (out_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                r_score[i]   <= '0;
                r_nz_cap[i]  <= '0;
                r_pay_cap[i] <= '0;
            end
            r_flags      <= '0;
            r_uv_flag    <= 1'b0;
            r_uv_nz      <= '0;
            r_cmp_cnt    <= '0;
            r_best_i     <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_payload    <= '0;
            r_nz         <= '0;
            r_skipped    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmp_cnt <= '0;
                    if (start) begin
                        r_flags   <= '0;
                        r_uv_flag <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    r_cmp_cnt <= '0;
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (cand_done[i]) begin
                            r_score[i]   <= cand_score[i*SCORE_W +: SCORE_W];
                            r_nz_cap[i]  <= {cand_nz[i*32 + 24], cand_nz[i*32 +: 16]};
                            r_pay_cap[i] <= cand_payload[i*PAYLOAD_W +: PAYLOAD_W];
                            r_flags[i]   <= 1'b1;
                        end
                    end
                    if (uv_done) begin
                        r_uv_nz   <= uv_nz[23:16];
                        r_uv_flag <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    r_cmp_cnt <= r_cmp_cnt + 1'b1;
                    if (r_cmp_cnt == '0) begin
                        r_best_i     <= '0;
                        r_best_score <= r_score[0];
                    end else if (r_cmp_cnt < CNT_W'(NUM_CAND)) begin
                        // Strict less-than keeps the lower index on ties.
                        if (r_score[w_cmp_i] < r_best_score) begin
                            r_best_i     <= w_cmp_i;
                            r_best_score <= r_score[w_cmp_i];
                        end
                    end else begin
                        r_best_idx <= 2'(r_best_i);
                        r_payload  <= r_pay_cap[r_best_i];
                        r_nz       <= w_nz_merged;
                        r_skipped  <= (w_nz_merged == 32'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign best_idx  = r_best_idx;
    assign mbtype    = {6'b0, r_best_idx};
    assign payload   = r_payload;
    assign nz        = r_nz;
    assign skipped   = r_skipped;

endmodule
`default_nettype wire

// File: tb/tb_mb_mode_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_mb_mode_select
// Description : Directed self-checking bench for mb_mode_select (two
//               candidates, small payload/score widths, TIMEOUT = 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mb_mode_select;

    localparam int NC = 2;
    localparam int SW = 16;
    localparam int PW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [NC-1:0]    cand_done;
    logic [NC*SW-1:0] cand_score;
    logic [NC*32-1:0] cand_nz;
    logic [NC*PW-1:0] cand_payload;
    logic             uv_done;
    logic [31:0]      uv_nz;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       best_idx;
    logic [7:0]       mbtype;
    logic [PW-1:0]    payload;
    logic [31:0]      nz;
    logic             skipped;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    mb_mode_select #(
        .NUM_CAND (NC),
        .PAYLOAD_W(PW),
        .SCORE_W  (SW),
        .DC_MASK  (2'b01),
        .TIMEOUT  (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cand_done   (cand_done),
        .cand_score  (cand_score),
        .cand_nz     (cand_nz),
        .cand_payload(cand_payload),
        .uv_done     (uv_done),
        .uv_nz       (uv_nz),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .best_idx    (best_idx),
        .mbtype      (mbtype),
        .payload     (payload),
        .nz          (nz),
        .skipped     (skipped),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cand(input int i, input logic [SW-1:0] s,
                            input logic [31:0] n, input logic [PW-1:0] p);
        cand_score[i*SW +: SW]   = s;
        cand_nz[i*32 +: 32]      = n;
        cand_payload[i*PW +: PW] = p;
    endtask

    task automatic do_done(input logic [NC-1:0] m, input logic u);
        cand_done = m;
        uv_done   = u;
        tick;
        cand_done = '0;
        uv_done   = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: valid=%b busy=%b err=%b, required 0 0 0", out_valid, busy, err);
        end
        checks++;
        if (best_idx !== 2'd0 || mbtype !== 8'd0 || payload !== '0 || nz !== 32'd0 || skipped !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: idx=%0d mbtype=%0d payload=%h nz=%h skipped=%b, required all 0",
                     best_idx, mbtype, payload, nz, skipped);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        do_start;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b, required 1", busy);
        end
        // First c0 result is overwritten by a later c0 done.
        set_cand(0, 16'd10,  32'h0100_1234, 16'hAAAA);
        do_done(2'b01, 1'b0);
        set_cand(0, 16'd100, 32'h0100_1234, 16'hAAAA);
        do_done(2'b01, 1'b0);
        set_cand(1, 16'd50,  32'h0100_5678, 16'h5555);
        uv_nz = 32'hFF03_FF00;
        do_done(2'b10, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick;
            checks++;
            if (out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL basic_latency: edge %0d valid=%b, required %b", k, out_valid, (k == 3));
            end
        end
        checks++;
        if (best_idx !== 2'd1 || mbtype !== 8'd1) begin
            errors++;
            $display("FAIL basic_idx: idx=%0d mbtype=%0d, required 1 1", best_idx, mbtype);
        end
        checks++;
        if (nz !== 32'h0003_5678 || skipped !== 1'b0) begin
            errors++;
            $display("FAIL basic_nz: nz=%h skipped=%b, required 00035678 0", nz, skipped);
        end
        checks++;
        if (payload !== 16'h5555) begin
            errors++;
            $display("FAIL basic_payload: payload=%h, required 5555", payload);
        end
        handshake;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: valid=%b busy=%b err=%b, required 0 0 0", out_valid, busy, err);
        end
    endtask

    task automatic test_tie;
        do_start;
        set_cand(0, 16'd77, 32'h0100_0000, 16'h1111);
        set_cand(1, 16'd77, 32'h0000_0000, 16'h2222);
        uv_nz = 32'd0;
        do_done(2'b11, 1'b1);
        tick; tick; tick;
        checks++;
        if (out_valid !== 1'b1 || best_idx !== 2'd0 || payload !== 16'h1111) begin
            errors++;
            $display("FAIL tie_idx: valid=%b idx=%0d payload=%h, required 1 0 1111", out_valid, best_idx, payload);
        end
        checks++;
        if (nz !== 32'h0100_0000 || skipped !== 1'b0) begin
            errors++;
            $display("FAIL tie_nz: nz=%h skipped=%b, required 01000000 0", nz, skipped);
        end
        handshake;
    endtask

    task automatic test_skipped;
        do_start;
        set_cand(0, 16'd5, 32'd0, 16'h0F0F);
        set_cand(1, 16'd9, 32'd0, 16'hF0F0);
        uv_nz = 32'd0;
        do_done(2'b11, 1'b0);
        tick; tick; tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL skip_wait_uv: valid=%b busy=%b, required 0 1", out_valid, busy);
        end
        do_done(2'b00, 1'b1);
        tick; tick; tick;
        checks++;
        if (out_valid !== 1'b1 || skipped !== 1'b1 || nz !== 32'd0 || best_idx !== 2'd0) begin
            errors++;
            $display("FAIL skip_result: valid=%b skipped=%b nz=%h idx=%0d, required 1 1 00000000 0",
                     out_valid, skipped, nz, best_idx);
        end
        handshake;
    endtask

    task automatic test_back_to_back;
        do_start;
        set_cand(0, 16'd30, 32'd0,          16'hC0C0);
        set_cand(1, 16'd20, 32'h0000_00FF, 16'hC1C1);
        uv_nz = 32'h00FF_0000;
        do_done(2'b11, 1'b1);
        tick; tick; tick;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start = 1'b1;
            tick;
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || best_idx !== 2'd1 || nz !== 32'h00FF_00FF || payload !== 16'hC1C1) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d valid=%b idx=%0d nz=%h payload=%h, required 1 1 00ff00ff c1c1",
                         k, out_valid, best_idx, nz, payload);
            end
        end
        handshake;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        do_start;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: busy=%b, required 1", busy);
        end
        set_cand(0, 16'd9, 32'd0,          16'hB0B0);
        set_cand(1, 16'd2, 32'h0000_0001, 16'hB1B1);
        uv_nz = 32'd0;
        do_done(2'b11, 1'b1);
        tick; tick; tick;
        checks++;
        if (out_valid !== 1'b1 || best_idx !== 2'd1 || nz !== 32'h0000_0001 || payload !== 16'hB1B1) begin
            errors++;
            $display("FAIL b2b_result: valid=%b idx=%0d nz=%h payload=%h, required 1 1 00000001 b1b1",
                     out_valid, best_idx, nz, payload);
        end
        handshake;
    endtask

    task automatic test_reset_mid;
        do_start;
        set_cand(0, 16'd40, 32'h0100_0010, 16'h4040);
        set_cand(1, 16'd41, 32'd0,         16'h4141);
        uv_nz = 32'h0007_0000;
        do_done(2'b11, 1'b1);
        tick;
        checks++;
        if (busy !== 1'b1 || best_idx !== 2'd1) begin
            errors++;
            $display("FAIL midrst_pre: busy=%b idx=%0d, required 1 1", busy, best_idx);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || best_idx !== 2'd0 || mbtype !== 8'd0 ||
            payload !== '0 || nz !== 32'd0 || skipped !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b busy=%b err=%b idx=%0d mbtype=%0d payload=%h nz=%h skipped=%b, required all 0",
                     out_valid, busy, err, best_idx, mbtype, payload, nz, skipped);
        end
        tick;
        rst_n = 1'b1;
        tick;
        do_start;
        do_done(2'b11, 1'b1);
        tick; tick; tick;
        checks++;
        if (out_valid !== 1'b1 || best_idx !== 2'd0 || nz !== 32'h0107_0010 || payload !== 16'h4040) begin
            errors++;
            $display("FAIL midrst_fresh: valid=%b idx=%0d nz=%h payload=%h, required 1 0 01070010 4040",
                     out_valid, best_idx, nz, payload);
        end
        handshake;
    endtask

`ifdef MB_MODE_SELECT_TIMEOUT_EN
    task automatic test_timeout;
        int err_cnt   = 0;
        int err_at    = -1;
        int valid_cnt = 0;
        do_start;
        do_done(2'b11, 1'b0);
        for (int t = 2; t <= 15; t++) begin
            tick;
            if (err === 1'b1) begin
                err_cnt++;
                err_at = t;
            end
            if (out_valid === 1'b1) valid_cnt++;
        end
        checks++;
        if (err_cnt != 1 || err_at != 10) begin
            errors++;
            $display("FAIL timeout_err: pulses=%0d at edge %0d, required 1 at 10", err_cnt, err_at);
        end
        checks++;
        if (busy !== 1'b0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b valid_cycles=%0d, required 0 0", busy, valid_cnt);
        end
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        cand_done    = '0;
        cand_score   = '0;
        cand_nz      = '0;
        cand_payload = '0;
        uv_done      = 1'b0;
        uv_nz        = '0;
        out_ready    = 1'b0;

        test_reset;
        test_basic;
        test_tie;
        test_skipped;
        test_back_to_back;
        test_reset_mid;
`ifdef MB_MODE_SELECT_TIMEOUT_EN
        test_timeout;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
